// File: rtl/ps2_keyboard_state_pkg.sv
// ----------------------------------------------------------------------------
// ps2_keyboard_state_pkg
// Shared PS/2 scan-code set 2 definitions: prefix/break bytes, keyboard
// response codes, modifier key codes, the decoder state encoding and the
// modifier bookkeeping helpers used by ps2_keyboard_state.
// ----------------------------------------------------------------------------
package ps2_keyboard_state_pkg;

  // Prefix and break bytes
  localparam logic [7:0] SCAN_PREFIX_E0 = 8'hE0;
  localparam logic [7:0] SCAN_PREFIX_E1 = 8'hE1;
  localparam logic [7:0] SCAN_BREAK     = 8'hF0;

  // Keyboard-to-host response/status bytes; never key events
  localparam logic [7:0] SCAN_RESP_ERR0     = 8'h00;
  localparam logic [7:0] SCAN_RESP_BAT_OK   = 8'hAA;
  localparam logic [7:0] SCAN_RESP_ECHO     = 8'hEE;
  localparam logic [7:0] SCAN_RESP_ACK      = 8'hFA;
  localparam logic [7:0] SCAN_RESP_BAT_FAIL = 8'hFC;
  localparam logic [7:0] SCAN_RESP_RESEND   = 8'hFE;
  localparam logic [7:0] SCAN_RESP_ERR1     = 8'hFF;

  // Modifier key codes (R-ctrl, AltGr and both metas carry an E0 prefix)
  localparam logic [7:0] SCAN_LSHIFT = 8'h12;
  localparam logic [7:0] SCAN_RSHIFT = 8'h59;
  localparam logic [7:0] SCAN_CTRL   = 8'h14;
  localparam logic [7:0] SCAN_ALT    = 8'h11;
  localparam logic [7:0] SCAN_LMETA  = 8'h1F;
  localparam logic [7:0] SCAN_RMETA  = 8'h27;

  // Pause is E1 followed by seven more bytes; it is reported as one event
  localparam logic [7:0] SCAN_PAUSE    = 8'h77;
  localparam logic [2:0] E1_SKIP_BYTES = 3'd7;

  typedef enum logic [2:0] {
    IDLE,
    GOT_E0,
    GOT_F0,
    GOT_E0_F0,
    SKIP_E1
  } kbd_state_e;

  typedef struct packed {
    logic lshift;
    logic rshift;
    logic lctrl;
    logic rctrl;
    logic alt;
    logic altgr;
    logic lmeta;
    logic rmeta;
  } mod_t;

  function automatic logic is_response(input logic [7:0] code);
    return (code == SCAN_RESP_ERR0)     || (code == SCAN_RESP_BAT_OK) ||
           (code == SCAN_RESP_ECHO)     || (code == SCAN_RESP_ACK)    ||
           (code == SCAN_RESP_BAT_FAIL) || (code == SCAN_RESP_RESEND) ||
           (code == SCAN_RESP_ERR1);
  endfunction

  function automatic logic is_modifier(input logic [7:0] code, input logic ext);
    if (!ext) return (code == SCAN_LSHIFT) || (code == SCAN_RSHIFT) ||
                     (code == SCAN_CTRL)   || (code == SCAN_ALT);
    else      return (code == SCAN_CTRL)   || (code == SCAN_ALT)    ||
                     (code == SCAN_LMETA)  || (code == SCAN_RMETA);
  endfunction

  // Set (level=1, make) or clear (level=0, break) the bit for one key.
  // Codes that are not modifiers leave the set unchanged.
  function automatic mod_t apply_modifier(input mod_t m, input logic [7:0] code,
                                          input logic ext, input logic level);
    mod_t r;
    r = m;
    if (!ext) begin
      case (code)
        SCAN_LSHIFT: r.lshift = level;
        SCAN_RSHIFT: r.rshift = level;
        SCAN_CTRL:   r.lctrl  = level;
        SCAN_ALT:    r.alt    = level;
        default:     ;
      endcase
    end else begin
      case (code)
        SCAN_CTRL:   r.rctrl  = level;
        SCAN_ALT:    r.altgr  = level;
        SCAN_LMETA:  r.lmeta  = level;
        SCAN_RMETA:  r.rmeta  = level;
        default:     ;
      endcase
    end
    return r;
  endfunction

endpackage

// File: rtl/ps2_keyboard_state.sv
// ----------------------------------------------------------------------------
// ps2_keyboard_state
// Turns a stream of received PS/2 set-2 bytes into key make events and
// modifier levels. Prefixes (E0, F0, E1) are tracked by a small FSM; a
// pending prefix is abandoned after TIMEOUT_CYCLES strobe-free cycles.
//
// Ports
//   clk                  : clock, all logic on posedge
//   reset                : asynchronous active-low reset
//   scan_code_ready      : one-cycle strobe, scan_code valid
//   scan_code[7:0]       : received byte
//   keyboard_state_ready : one-cycle strobe, one cycle after the completing
//                          byte of a non-modifier make
//   scan_code_out[7:0]   : final code byte of the last event (held)
//   scan_code_extended   : last event had an E0/E1 prefix (held)
//   keyboard_shift/ctrl/alt/altgr/meta : current modifier levels
// ----------------------------------------------------------------------------
module ps2_keyboard_state
  import ps2_keyboard_state_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 2_500_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       scan_code_ready,
  input  logic [7:0] scan_code,
  output logic       keyboard_state_ready,
  output logic [7:0] scan_code_out,
  output logic       scan_code_extended,
  output logic       keyboard_shift,
  output logic       keyboard_ctrl,
  output logic       keyboard_alt,
  output logic       keyboard_altgr,
  output logic       keyboard_meta
);

  localparam int             TMO_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  kbd_state_e       state_q,   state_d;
  logic [2:0]       skip_q,    skip_d;
  logic [TMO_W-1:0] tmo_q,     tmo_d;
  mod_t             mods_q,    mods_d;
  logic             ready_q,   ready_d;
  logic [7:0]       code_q,    code_d;
  logic             ext_q,     ext_d;

  // Decoded make request from the current byte, resolved after the case
  logic             do_make;
  logic             make_ext;

  // NOTE: every signal assigned here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d  = state_q;
    skip_d   = skip_q;
    tmo_d    = tmo_q;
    mods_d   = mods_q;
    ready_d  = 1'b0;
    code_d   = code_q;
    ext_d    = ext_q;
    do_make  = 1'b0;
    make_ext = 1'b0;

    if (scan_code_ready) begin
      tmo_d = '0;
      case (state_q)
        IDLE: begin
          if (scan_code == SCAN_PREFIX_E0) begin
            state_d = GOT_E0;
          end else if (scan_code == SCAN_BREAK) begin
            state_d = GOT_F0;
          end else if (scan_code == SCAN_PREFIX_E1) begin
            state_d = SKIP_E1;
            skip_d  = E1_SKIP_BYTES;
          end else if (!is_response(scan_code)) begin
            do_make = 1'b1;
          end
        end
        GOT_E0: begin
          state_d = IDLE;
          if (scan_code == SCAN_BREAK) begin
            state_d = GOT_E0_F0;
          end else if ((scan_code != SCAN_LSHIFT) && (scan_code != SCAN_RSHIFT)) begin
            // E0 12 / E0 59 are fake shifts wrapped around some keys; drop them
            do_make  = 1'b1;
            make_ext = 1'b1;
          end
        end
        GOT_F0: begin
          state_d = IDLE;
          mods_d  = apply_modifier(mods_q, scan_code, 1'b0, 1'b0);
        end
        GOT_E0_F0: begin
          state_d = IDLE;
          mods_d  = apply_modifier(mods_q, scan_code, 1'b1, 1'b0);
        end
        SKIP_E1: begin
          // Pause bytes contain 14/F0 14, which must not touch ctrl
          if (skip_q == 3'd1) begin
            state_d = IDLE;
            ready_d = 1'b1;
            code_d  = SCAN_PAUSE;
            ext_d   = 1'b1;
          end else begin
            skip_d = skip_q - 3'd1;
          end
        end
        default: state_d = IDLE;
      endcase
    end else if (state_q != IDLE) begin
      // The increment is only reached below TMO_LAST, so the counter can
      // never wrap.
      if (tmo_q >= TMO_LAST) begin
        state_d = IDLE;
        tmo_d   = '0;
      end else begin
        tmo_d = tmo_q + 1'b1;
      end
    end

    if (do_make) begin
      if (is_modifier(scan_code, make_ext)) begin
        mods_d = apply_modifier(mods_q, scan_code, make_ext, 1'b1);
      end else begin
        ready_d = 1'b1;
        code_d  = scan_code;
        ext_d   = make_ext;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      skip_q  <= '0;
      tmo_q   <= '0;
      mods_q  <= '0;
      ready_q <= 1'b0;
      code_q  <= '0;
      ext_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      skip_q  <= skip_d;
      tmo_q   <= tmo_d;
      mods_q  <= mods_d;
      ready_q <= ready_d;
      code_q  <= code_d;
      ext_q   <= ext_d;
    end
  end

  assign keyboard_state_ready = ready_q;
  assign scan_code_out        = code_q;
  assign scan_code_extended   = ext_q;
  assign keyboard_shift       = mods_q.lshift | mods_q.rshift;
  assign keyboard_ctrl        = mods_q.lctrl  | mods_q.rctrl;
  assign keyboard_alt         = mods_q.alt;
  assign keyboard_altgr       = mods_q.altgr;
  assign keyboard_meta        = mods_q.lmeta  | mods_q.rmeta;

endmodule

// File: tb/tb_ps2_keyboard_state.sv
// ----------------------------------------------------------------------------
// tb_ps2_keyboard_state
// Directed bench for ps2_keyboard_state with a short timeout so the prefix
// abandonment path is reachable in a few cycles.
// ----------------------------------------------------------------------------
module tb_ps2_keyboard_state;

  localparam int unsigned TMO = 16;

  logic       clk;
  logic       reset;
  logic       scan_code_ready;
  logic [7:0] scan_code;
  logic       keyboard_state_ready;
  logic [7:0] scan_code_out;
  logic       scan_code_extended;
  logic       keyboard_shift;
  logic       keyboard_ctrl;
  logic       keyboard_alt;
  logic       keyboard_altgr;
  logic       keyboard_meta;

  int tests_run;
  int tests_failed;
  int ev_cnt;

  // {ready, code, ext} and {shift, ctrl, alt, altgr, meta}
  logic [9:0] evt;
  logic [4:0] mods;
  assign evt  = {keyboard_state_ready, scan_code_out, scan_code_extended};
  assign mods = {keyboard_shift, keyboard_ctrl, keyboard_alt, keyboard_altgr, keyboard_meta};

  ps2_keyboard_state #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk                  (clk),
    .reset                (reset),
    .scan_code_ready      (scan_code_ready),
    .scan_code            (scan_code),
    .keyboard_state_ready (keyboard_state_ready),
    .scan_code_out        (scan_code_out),
    .scan_code_extended   (scan_code_extended),
    .keyboard_shift       (keyboard_shift),
    .keyboard_ctrl        (keyboard_ctrl),
    .keyboard_alt         (keyboard_alt),
    .keyboard_altgr       (keyboard_altgr),
    .keyboard_meta        (keyboard_meta)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Each ready pulse spans exactly one negedge
  initial ev_cnt = 0;
  always @(negedge clk) if (keyboard_state_ready === 1'b1) ev_cnt++;

  // Called at posedge+1; strobes for one cycle and returns at posedge+1, so
  // consecutive calls give back-to-back strobes.
  task automatic send_byte(input logic [7:0] b);
    scan_code_ready = 1'b1;
    scan_code       = b;
    @(posedge clk); #1;
    scan_code_ready = 1'b0;
    scan_code       = 8'h00;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic pulse_reset();
    @(negedge clk); #2;
    reset = 1'b0;
    #4;
    reset = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    #3;
    reset = 1'b0;
    #2;
    tests_run++;
    if ({evt, mods} !== 15'h0) begin
      tests_failed++;
      $display("FAIL reset_outputs: got %h expected %h", {evt, mods}, 15'h0);
    end
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_single_make();
    int ev0;
    ev0 = ev_cnt;
    send_byte(8'h1C);
    tests_run++;
    if ({evt, mods} !== {1'b1, 8'h1C, 1'b0, 5'b00000}) begin
      tests_failed++;
      $display("FAIL make_1c: got %h expected %h", {evt, mods}, {1'b1, 8'h1C, 1'b0, 5'b00000});
    end
    idle(1);
    tests_run++;
    if (evt !== {1'b0, 8'h1C, 1'b0}) begin
      tests_failed++;
      $display("FAIL make_1c_held: got %h expected %h", evt, {1'b0, 8'h1C, 1'b0});
    end
    tests_run++;
    if (ev_cnt - ev0 !== 1) begin
      tests_failed++;
      $display("FAIL make_1c_count: got %0d expected 1", ev_cnt - ev0);
    end
  endtask

  task automatic test_shift();
    int ev0;
    ev0 = ev_cnt;
    send_byte(8'h12); idle(1);
    send_byte(8'h59);
    tests_run++;
    if ({keyboard_state_ready, keyboard_shift} !== 2'b01) begin
      tests_failed++;
      $display("FAIL shift_make: got %b expected %b", {keyboard_state_ready, keyboard_shift}, 2'b01);
    end
    idle(1);
    send_byte(8'h1C);
    tests_run++;
    if ({evt, keyboard_shift} !== {1'b1, 8'h1C, 1'b0, 1'b1}) begin
      tests_failed++;
      $display("FAIL shift_event1: got %h expected %h", {evt, keyboard_shift}, {1'b1, 8'h1C, 1'b0, 1'b1});
    end
    idle(1);
    send_byte(8'hF0); send_byte(8'h12);
    tests_run++;
    if (keyboard_shift !== 1'b1) begin
      tests_failed++;
      $display("FAIL shift_one_side_held: got %b expected 1", keyboard_shift);
    end
    idle(1);
    send_byte(8'h1C);
    tests_run++;
    if ({evt, keyboard_shift} !== {1'b1, 8'h1C, 1'b0, 1'b1}) begin
      tests_failed++;
      $display("FAIL shift_event2: got %h expected %h", {evt, keyboard_shift}, {1'b1, 8'h1C, 1'b0, 1'b1});
    end
    idle(1);
    send_byte(8'hF0); send_byte(8'h59);
    idle(1);
    tests_run++;
    if (keyboard_shift !== 1'b0) begin
      tests_failed++;
      $display("FAIL shift_released: got %b expected 0", keyboard_shift);
    end
    tests_run++;
    if (ev_cnt - ev0 !== 2) begin
      tests_failed++;
      $display("FAIL shift_count: got %0d expected 2", ev_cnt - ev0);
    end
  endtask

  task automatic test_altgr();
    int ev0;
    ev0 = ev_cnt;
    send_byte(8'hE0); send_byte(8'h11);
    idle(1);
    send_byte(8'h15);
    tests_run++;
    if ({evt, keyboard_alt, keyboard_altgr} !== {1'b1, 8'h15, 1'b0, 2'b01}) begin
      tests_failed++;
      $display("FAIL altgr_event: got %h expected %h", {evt, keyboard_alt, keyboard_altgr}, {1'b1, 8'h15, 1'b0, 2'b01});
    end
    send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h11);
    idle(1);
    tests_run++;
    if ({keyboard_alt, keyboard_altgr} !== 2'b00) begin
      tests_failed++;
      $display("FAIL altgr_released: got %b expected %b", {keyboard_alt, keyboard_altgr}, 2'b00);
    end
    send_byte(8'h11);
    tests_run++;
    if ({keyboard_state_ready, keyboard_alt, keyboard_altgr} !== 3'b010) begin
      tests_failed++;
      $display("FAIL alt_make: got %b expected %b", {keyboard_state_ready, keyboard_alt, keyboard_altgr}, 3'b010);
    end
    send_byte(8'hF0); send_byte(8'h11);
    idle(1);
    tests_run++;
    if (ev_cnt - ev0 !== 1 || keyboard_alt !== 1'b0) begin
      tests_failed++;
      $display("FAIL altgr_count: got events %0d alt %b expected events 1 alt 0", ev_cnt - ev0, keyboard_alt);
    end
  endtask

  task automatic test_ctrl_meta();
    int ev0;
    ev0 = ev_cnt;
    send_byte(8'h14); send_byte(8'hE0); send_byte(8'h14);
    send_byte(8'hF0); send_byte(8'h14);
    tests_run++;
    if (keyboard_ctrl !== 1'b1) begin
      tests_failed++;
      $display("FAIL ctrl_right_held: got %b expected 1", keyboard_ctrl);
    end
    send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h14);
    tests_run++;
    if (keyboard_ctrl !== 1'b0) begin
      tests_failed++;
      $display("FAIL ctrl_released: got %b expected 0", keyboard_ctrl);
    end
    send_byte(8'hE0); send_byte(8'h1F); send_byte(8'hE0); send_byte(8'h27);
    send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h1F);
    tests_run++;
    if (keyboard_meta !== 1'b1) begin
      tests_failed++;
      $display("FAIL meta_right_held: got %b expected 1", keyboard_meta);
    end
    send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h27);
    idle(1);
    tests_run++;
    if (keyboard_meta !== 1'b0 || ev_cnt - ev0 !== 0) begin
      tests_failed++;
      $display("FAIL meta_released: got meta %b events %0d expected meta 0 events 0", keyboard_meta, ev_cnt - ev0);
    end
  endtask

  task automatic test_extended();
    int ev0;
    logic shift_seen;
    ev0 = ev_cnt;
    shift_seen = 1'b0;
    send_byte(8'hE0); send_byte(8'h75);
    tests_run++;
    if (evt !== {1'b1, 8'h75, 1'b1}) begin
      tests_failed++;
      $display("FAIL ext_75: got %h expected %h", evt, {1'b1, 8'h75, 1'b1});
    end
    send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h75);
    send_byte(8'hE0); send_byte(8'h12);
    shift_seen = shift_seen | keyboard_shift;
    send_byte(8'hE0);
    shift_seen = shift_seen | keyboard_shift;
    send_byte(8'h7C);
    shift_seen = shift_seen | keyboard_shift;
    tests_run++;
    if (evt !== {1'b1, 8'h7C, 1'b1}) begin
      tests_failed++;
      $display("FAIL ext_7c: got %h expected %h", evt, {1'b1, 8'h7C, 1'b1});
    end
    idle(1);
    tests_run++;
    if (ev_cnt - ev0 !== 2 || shift_seen !== 1'b0) begin
      tests_failed++;
      $display("FAIL ext_count: got events %0d shift %b expected events 2 shift 0", ev_cnt - ev0, shift_seen);
    end
  endtask

  // Pause bytes arrive back-to-back
  task automatic test_back_to_back_pause();
    int ev0;
    logic ctrl_seen;
    logic [7:0] seq [8];
    seq = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};
    ev0 = ev_cnt;
    ctrl_seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      send_byte(seq[i]);
      ctrl_seen = ctrl_seen | keyboard_ctrl;
    end
    tests_run++;
    if (evt !== {1'b1, 8'h77, 1'b1}) begin
      tests_failed++;
      $display("FAIL pause_event: got %h expected %h", evt, {1'b1, 8'h77, 1'b1});
    end
    idle(1);
    tests_run++;
    if (ev_cnt - ev0 !== 1 || ctrl_seen !== 1'b0) begin
      tests_failed++;
      $display("FAIL pause_count: got events %0d ctrl %b expected events 1 ctrl 0", ev_cnt - ev0, ctrl_seen);
    end
  endtask

  task automatic test_typematic_and_responses();
    int ev0;
    logic [7:0] resp [7];
    resp = '{8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFE, 8'hFF};
    ev0 = ev_cnt;
    send_byte(8'h1C); send_byte(8'h1C); send_byte(8'h1C);
    idle(1);
    tests_run++;
    if (ev_cnt - ev0 !== 3) begin
      tests_failed++;
      $display("FAIL typematic_count: got %0d expected 3", ev_cnt - ev0);
    end
    ev0 = ev_cnt;
    for (int i = 0; i < 7; i++) send_byte(resp[i]);
    idle(1);
    tests_run++;
    if (ev_cnt - ev0 !== 0 || evt !== {1'b0, 8'h1C, 1'b0}) begin
      tests_failed++;
      $display("FAIL responses_ignored: got events %0d evt %h expected events 0 evt %h", ev_cnt - ev0, evt, {1'b0, 8'h1C, 1'b0});
    end
  endtask

  task automatic test_timeout();
    send_byte(8'hE0);
    idle(TMO - 1);
    send_byte(8'h7C);
    tests_run++;
    if (evt !== {1'b1, 8'h7C, 1'b1}) begin
      tests_failed++;
      $display("FAIL timeout_not_yet: got %h expected %h", evt, {1'b1, 8'h7C, 1'b1});
    end
    send_byte(8'hE0);
    idle(TMO + 1);
    send_byte(8'h1C);
    tests_run++;
    if (evt !== {1'b1, 8'h1C, 1'b0}) begin
      tests_failed++;
      $display("FAIL timeout_expired: got %h expected %h", evt, {1'b1, 8'h1C, 1'b0});
    end
  endtask

  task automatic test_reset_mid();
    send_byte(8'h12); send_byte(8'hE0);
    @(negedge clk); #2;
    reset = 1'b0;
    #1;
    tests_run++;
    if ({evt, mods} !== 15'h0) begin
      tests_failed++;
      $display("FAIL reset_async: got %h expected %h", {evt, mods}, 15'h0);
    end
    #3;
    reset = 1'b1;
    @(posedge clk); #1;
    send_byte(8'h1C);
    tests_run++;
    if ({evt, keyboard_shift} !== {1'b1, 8'h1C, 1'b0, 1'b0}) begin
      tests_failed++;
      $display("FAIL reset_mid_e0: got %h expected %h", {evt, keyboard_shift}, {1'b1, 8'h1C, 1'b0, 1'b0});
    end
    send_byte(8'hE0);
    pulse_reset();
    send_byte(8'h1C);
    tests_run++;
    if (evt !== {1'b1, 8'h1C, 1'b0}) begin
      tests_failed++;
      $display("FAIL reset_pulse_e0: got %h expected %h", evt, {1'b1, 8'h1C, 1'b0});
    end
  endtask

  initial begin
    tests_run       = 0;
    tests_failed    = 0;
    reset           = 1'b1;
    scan_code_ready = 1'b0;
    scan_code       = 8'h00;
    test_reset();
    test_single_make();
    test_shift();
    test_altgr();
    test_ctrl_meta();
    test_extended();
    test_back_to_back_pause();
    test_typematic_and_responses();
    test_timeout();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/ps2_keyboard_state.md
PS2_KEYBOARD_STATE -- requirements
Module: ps2_keyboard_state

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 2_500_000, the number of idle cycles after which a pending prefix is abandoned (50 ms at 50 MHz).
REQ-002 SHALL have port clk, input, 1, the single clock; all logic on posedge.
REQ-003 SHALL have port reset, input, 1, asynchronous, active-low reset.
REQ-004 SHALL have port scan_code_ready, input, 1, one-cycle strobe marking a valid received PS/2 byte.
REQ-005 SHALL have port scan_code, input, 8, the received set-2 byte, valid when scan_code_ready=1.
REQ-006 SHALL have port keyboard_state_ready, output, 1, one-cycle strobe marking a complete non-modifier make event.
REQ-007 SHALL have port scan_code_out, output, 8, the final code byte of the event.
REQ-008 SHALL have port scan_code_extended, output, 1, high when the event carried an E0 or E1 prefix.
REQ-009 SHALL have ports keyboard_shift, keyboard_ctrl, keyboard_alt, keyboard_altgr and keyboard_meta, each output, 1, the current modifier levels.

Function
REQ-010 SHALL be a registered FSM with states IDLE, GOT_E0, GOT_F0, GOT_E0_F0 and SKIP_E1.
REQ-011 SHALL handle strobed bytes in IDLE as follows.
- E0 -> GOT_E0.
- F0 -> GOT_F0.
- E1 -> SKIP_E1, with skip counter = 7.
- 00, AA, EE, FA, FC, FE, FF -> ignored; stay in IDLE.
- Any other byte -> make event, non-extended.
REQ-012 SHALL handle strobed bytes in GOT_E0 as follows.
- F0 -> GOT_E0_F0.
- 12 or 59 (fake shifts) -> ignored, IDLE.
- Any other byte -> extended make event, IDLE.
REQ-013 SHALL treat any strobed byte in GOT_F0 or GOT_E0_F0 as a non-extended or extended break respectively, then return to IDLE; breaks never strobe keyboard_state_ready.
REQ-014 SHALL, in SKIP_E1, decrement the counter per strobed byte; at the 7th byte it SHALL emit one extended event with code 77 (Pause) and return to IDLE, with no modifier change.
REQ-015 SHALL update internal modifier bits on make (set) and break (clear) with this mapping.
- L-shift 12, R-shift 59.
- L-ctrl 14, R-ctrl E0 14.
- Alt 11.
- AltGr E0 11.
- L-meta E0 1F, R-meta E0 27.
REQ-016 SHALL drive keyboard_shift = L|R shift, keyboard_ctrl = L|R ctrl and keyboard_meta = L|R meta; releasing one side SHALL keep the output high while the other side is held.
REQ-017 SHALL NOT strobe keyboard_state_ready for modifier makes.
REQ-018 SHALL assert keyboard_state_ready exactly one cycle after the completing strobe; scan_code_out and scan_code_extended SHALL be registered in that same cycle and held until the next event.
REQ-019 SHALL present, during the strobe, modifier outputs that reflect all bytes preceding the event.
REQ-020 SHALL emit one event per repeated make (typematic); there is no deduplication.
REQ-021 SHALL process every strobed byte in one cycle with no backpressure; back-to-back strobes on consecutive cycles SHALL be handled.
REQ-022 SHALL reset the timeout counter on every strobe while in a non-IDLE state; after TIMEOUT_CYCLES cycles without a strobe the FSM SHALL return to IDLE, with modifiers unchanged and no event.
REQ-023 SHALL size the timeout counter as $clog2(TIMEOUT_CYCLES+1) bits, saturating with no wrap-around.

Reset
REQ-024 SHALL, while reset=0, force IDLE, clear all modifier bits and counters, and drive all outputs 0; the effect SHALL be immediate and asynchronous.
REQ-025 SHALL discard a partial sequence (E0/F0/E1) when reset is asserted mid-operation; the first strobe after reset release SHALL be decoded from IDLE.

Structure
REQ-026 SHALL take prefix and response constants (SCAN_PREFIX_E0=E0, SCAN_PREFIX_E1=E1, SCAN_BREAK=F0, keyboard response codes) and modifier scan codes from the shared set-2 scan-code include, not local literals.
REQ-027 SHALL be a single module with no sub-module; the timeout counter and FSM are inline, and outputs feed the ASCII translator unchanged.

Verification
REQ-028 SHALL cover: strobe 1C -> one cycle later keyboard_state_ready=1, scan_code_out=1C, scan_code_extended=0, all modifiers 0.
REQ-029 SHALL cover: 12, 59, 1C, F0 12, 1C, F0 59 -> first 1C event with shift=1; shift stays 1 after F0 12; second 1C event with shift=1; shift=0 after F0 59; no event for any break.
REQ-030 SHALL cover: E0 11, 15, E0 F0 11 -> altgr=1 and alt=0 during the 15 event; altgr=0 after; exactly one event in total.
REQ-031 SHALL cover: E0 75, E0 F0 75, E0 12 E0 7C -> one event 75 ext=1; one event 7C ext=1; shift never asserted.
REQ-032 SHALL cover: E1 14 77 E1 F0 14 F0 77 -> exactly one event, code 77 ext=1, ctrl=0 throughout.
REQ-033 SHALL cover: E0, idle TIMEOUT_CYCLES+1 cycles, then 1C -> event ext=0; separately, E0, reset pulse, 1C -> event ext=0.
